// File: rtl/reorder_buffer.sv
// Reorder buffer: dual-lane dispatch allocation, dual writeback, dual in-order
// retire, and precise exception flush.
//
// Entries live in a circular buffer addressed by head (oldest) and tail
// (next free) pointers that carry one extra wrap bit, so occupancy is simply
// tail - head and full/empty need no extra state.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   alloc_*         per-lane dispatch request (valid, dst areg, new/old preg, pc)
//   alloc_ready     at least two entries free (from registered occupancy)
//   alloc_idx       ROB index given to each lane this cycle
//   wb_valid/idx/exc  completion ports (port 1 wins on an index collision)
//   commit_*        per-lane retire strobe and retired-entry fields
//   flush/flush_pc  exception at head: pulse and faulting pc
//   count/empty/full  occupancy status
module reorder_buffer #(
  parameter int DEPTH  = 32,
  parameter int AREG_W = 5,
  parameter int PREG_W = 6,
  parameter int PC_W   = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             alloc_valid,
  input  logic [1:0][AREG_W-1:0] alloc_dst_areg,
  input  logic [1:0][PREG_W-1:0] alloc_dst_preg,
  input  logic [1:0][PREG_W-1:0] alloc_old_preg,
  input  logic [1:0][PC_W-1:0]   alloc_pc,
  output logic                   alloc_ready,
  output logic [1:0][IDX_W-1:0]  alloc_idx,
  input  logic [1:0]             wb_valid,
  input  logic [1:0][IDX_W-1:0]  wb_idx,
  input  logic [1:0]             wb_exc,
  output logic [1:0]             commit_valid,
  output logic [1:0][AREG_W-1:0] commit_areg,
  output logic [1:0][PREG_W-1:0] commit_preg,
  output logic [1:0][PREG_W-1:0] commit_old_preg,
  output logic [1:0][PC_W-1:0]   commit_pc,
  output logic                   flush,
  output logic [PC_W-1:0]        flush_pc,
  output logic [IDX_W:0]         count,
  output logic                   empty,
  output logic                   full
);

  localparam logic [IDX_W:0]   DEPTH_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);

  logic [IDX_W:0]    head, tail;
  logic [DEPTH-1:0]  ent_valid, ent_done, ent_exc;
  logic [AREG_W-1:0] ent_areg     [DEPTH];
  logic [PREG_W-1:0] ent_preg     [DEPTH];
  logic [PREG_W-1:0] ent_old_preg [DEPTH];
  logic [PC_W-1:0]   ent_pc       [DEPTH];

  logic [IDX_W-1:0]  head_idx, head1_idx;
  logic              head_done, head1_done;
  logic [1:0]        alloc_fire;

  function automatic logic [IDX_W:0] pop2(input logic [1:0] v);
    return (IDX_W+1)'(v[0]) + (IDX_W+1)'(v[1]);
  endfunction

  always_comb begin
    count       = tail - head;
    empty       = (count == '0);
    full        = (count == DEPTH_CNT);
    // Same-cycle retires are deliberately not credited here, keeping the
    // ready path off the commit logic.
    alloc_ready = ((DEPTH_CNT - count) >= (IDX_W+1)'(2));

    alloc_idx[0] = tail[IDX_W-1:0];
    alloc_idx[1] = tail[IDX_W-1:0] + ONE_IDX;
    // Lane 1 without lane 0 is an illegal request; drop both lanes.
    alloc_fire[0] = alloc_ready & alloc_valid[0];
    alloc_fire[1] = alloc_ready & alloc_valid[0] & alloc_valid[1];

    head_idx   = head[IDX_W-1:0];
    head1_idx  = head_idx + ONE_IDX;
    head_done  = ent_valid[head_idx] & ent_done[head_idx];
    head1_done = ent_valid[head1_idx] & ent_done[head1_idx];

    flush    = head_done & ent_exc[head_idx];
    flush_pc = flush ? ent_pc[head_idx] : '0;

    commit_valid[0] = head_done & ~ent_exc[head_idx];
    // An exception on head+1 only blocks lane 1; it flushes once it is head.
    commit_valid[1] = commit_valid[0] & head1_done & ~ent_exc[head1_idx];

    commit_areg[0]     = ent_areg[head_idx];
    commit_areg[1]     = ent_areg[head1_idx];
    commit_preg[0]     = ent_preg[head_idx];
    commit_preg[1]     = ent_preg[head1_idx];
    commit_old_preg[0] = ent_old_preg[head_idx];
    commit_old_preg[1] = ent_old_preg[head1_idx];
    commit_pc[0]       = ent_pc[head_idx];
    commit_pc[1]       = ent_pc[head1_idx];
  end

  // Control state: pointers and per-entry status bits.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
      ent_exc   <= '0;
    end else begin
      // Port 1 is applied last so it wins on a shared index.
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p] && ent_valid[wb_idx[p]]) begin
          ent_done[wb_idx[p]] <= 1'b1;
          ent_exc[wb_idx[p]]  <= wb_exc[p];
        end
      end
      if (commit_valid[0]) ent_valid[head_idx]  <= 1'b0;
      if (commit_valid[1]) ent_valid[head1_idx] <= 1'b0;
      // Allocation only targets free entries, so it never collides with a
      // writeback or a retire of the same index.
      for (int l = 0; l < 2; l++) begin
        if (alloc_fire[l]) begin
          ent_valid[alloc_idx[l]] <= 1'b1;
          ent_done[alloc_idx[l]]  <= 1'b0;
          ent_exc[alloc_idx[l]]   <= 1'b0;
        end
      end
      head <= head + pop2(commit_valid);
      tail <= tail + pop2(alloc_fire);
    end
  end

  // Payload fields; meaningful only while the entry's valid bit is set.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (alloc_fire[l]) begin
        ent_areg[alloc_idx[l]]     <= alloc_dst_areg[l];
        ent_preg[alloc_idx[l]]     <= alloc_dst_preg[l];
        ent_old_preg[alloc_idx[l]] <= alloc_old_preg[l];
        ent_pc[alloc_idx[l]]       <= alloc_pc[l];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus randomized traffic,
// checked against an in-order queue model of the outstanding instructions.
module tb_reorder_buffer;
  localparam int DEPTH  = 32;
  localparam int AREG_W = 5;
  localparam int PREG_W = 6;
  localparam int PC_W   = 32;
  localparam int IDX_W  = $clog2(DEPTH);

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [1:0]             alloc_valid;
  logic [1:0][AREG_W-1:0] alloc_dst_areg;
  logic [1:0][PREG_W-1:0] alloc_dst_preg;
  logic [1:0][PREG_W-1:0] alloc_old_preg;
  logic [1:0][PC_W-1:0]   alloc_pc;
  logic                   alloc_ready;
  logic [1:0][IDX_W-1:0]  alloc_idx;
  logic [1:0]             wb_valid;
  logic [1:0][IDX_W-1:0]  wb_idx;
  logic [1:0]             wb_exc;
  logic [1:0]             commit_valid;
  logic [1:0][AREG_W-1:0] commit_areg;
  logic [1:0][PREG_W-1:0] commit_preg;
  logic [1:0][PREG_W-1:0] commit_old_preg;
  logic [1:0][PC_W-1:0]   commit_pc;
  logic                   flush;
  logic [PC_W-1:0]        flush_pc;
  logic [IDX_W:0]         count;
  logic                   empty;
  logic                   full;

  reorder_buffer #(.DEPTH(DEPTH), .AREG_W(AREG_W), .PREG_W(PREG_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dst_areg(alloc_dst_areg),
    .alloc_dst_preg(alloc_dst_preg), .alloc_old_preg(alloc_old_preg),
    .alloc_pc(alloc_pc), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_exc(wb_exc),
    .commit_valid(commit_valid), .commit_areg(commit_areg),
    .commit_preg(commit_preg), .commit_old_preg(commit_old_preg),
    .commit_pc(commit_pc), .flush(flush), .flush_pc(flush_pc),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Model: program-ordered queue of in-flight instructions.
  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic [PREG_W-1:0] old;
    int                idx;
    int                done_cyc;  // cycle whose writeback completed it, -1 if pending
    bit                exc;
  } ent_t;

  ent_t exp_q[$];
  int   model_tail = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit ready_at(input ent_t e);
    return (e.done_cyc >= 0) && (e.done_cyc < cyc);
  endfunction

  function automatic int pick_pending();
    int c[$];
    foreach (exp_q[i]) if (exp_q[i].done_cyc < 0) c.push_back(exp_q[i].idx);
    if (c.size() == 0) return -1;
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  function automatic bit is_live(input int idx);
    foreach (exp_q[i]) if (exp_q[i].idx == idx) return 1'b1;
    return 1'b0;
  endfunction

  task automatic mark(input int idx, input bit exc);
    ent_t e;
    foreach (exp_q[i]) begin
      if (exp_q[i].idx == idx) begin
        e = exp_q[i];
        if (e.done_cyc < 0 || e.done_cyc == cyc) begin
          e.done_cyc = cyc;
          e.exc      = exc;
          exp_q[i]   = e;
        end
      end
    end
  endtask

  task automatic check_status();
    chk("count", count, exp_q.size());
    chk("empty", empty, exp_q.size() == 0);
    chk("full", full, exp_q.size() == DEPTH);
    chk("alloc_ready", alloc_ready, (DEPTH - exp_q.size()) >= 2);
    chk("alloc_idx0", alloc_idx[0], model_tail % DEPTH);
    chk("alloc_idx1", alloc_idx[1], (model_tail + 1) % DEPTH);
  endtask

  // Called at posedge+1: check registered status, present one cycle of inputs.
  task automatic step(input logic [1:0] av, input logic [PC_W-1:0] pc0, input logic [PC_W-1:0] pc1,
                      input logic [1:0] wv, input int wi0, input int wi1, input logic [1:0] we);
    ent_t e;
    bit   rdy;
    check_status();
    alloc_valid = av;
    alloc_pc[0] = pc0;
    alloc_pc[1] = pc1;
    for (int l = 0; l < 2; l++) begin
      alloc_dst_areg[l] = AREG_W'($urandom);
      alloc_dst_preg[l] = PREG_W'($urandom);
      alloc_old_preg[l] = PREG_W'($urandom);
    end
    wb_valid  = wv;
    wb_idx[0] = IDX_W'(wi0);
    wb_idx[1] = IDX_W'(wi1);
    wb_exc    = we;
    if (wv[0]) mark(wi0 % DEPTH, we[0]);
    if (wv[1]) mark(wi1 % DEPTH, we[1]);
    rdy = (DEPTH - exp_q.size()) >= 2;
    for (int l = 0; l < 2; l++) begin
      if (rdy && av[0] && (l == 0 || av[1])) begin
        e.pc = alloc_pc[l]; e.areg = alloc_dst_areg[l];
        e.preg = alloc_dst_preg[l]; e.old = alloc_old_preg[l];
        e.idx = model_tail % DEPTH; e.done_cyc = -1; e.exc = 1'b0;
        exp_q.push_back(e);
        model_tail++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(2'b00, '0, '0, 2'b00, 0, 0, 2'b00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    alloc_valid = 2'b00;
    wb_valid = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_idx0", alloc_idx[0], 0);
    chk("rst_idx1", alloc_idx[1], 1);
    chk("rst_commit", commit_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_flush_pc", flush_pc, 0);
  endtask

  task automatic drain();
    int a, b, k;
    logic [1:0] wv;
    k = 0;
    while ((exp_q.size() != 0 || !empty) && k < 400) begin
      a = pick_pending();
      b = pick_pending();
      wv[0] = (a >= 0);
      wv[1] = (b >= 0);
      step(2'b00, '0, '0, wv, (a < 0) ? 0 : a, (b < 0) ? 0 : b, 2'b00);
      k++;
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
  endtask

  task automatic random_run(input int n, input int wbp, input int excp);
    logic [1:0] av, wv, we;
    int wi[2];
    int r;
    for (int k = 0; k < n; k++) begin
      r  = $urandom_range(0, 99);
      av = (r < 5) ? 2'b10 : (r < 40) ? 2'b11 : (r < 70) ? 2'b01 : 2'b00;
      wv = 2'b00; we = 2'b00; wi[0] = 0; wi[1] = 0;
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 99) < wbp) begin
          if ($urandom_range(0, 9) == 0) begin
            int ri;
            ri = $urandom_range(0, DEPTH - 1);
            if (!is_live(ri)) begin wv[p] = 1'b1; wi[p] = ri; end
          end else if (p == 1 && wv[0] && $urandom_range(0, 7) == 0) begin
            wv[1] = 1'b1; wi[1] = wi[0];
          end else begin
            int c;
            c = pick_pending();
            if (c >= 0) begin wv[p] = 1'b1; wi[p] = c; end
          end
          we[p] = ($urandom_range(0, 99) < excp);
        end
      end
      step(av, $urandom, $urandom, wv, wi[0], wi[1], we);
    end
  endtask

  // Monitor: compares retire/flush activity against the model mid-cycle.
  always @(negedge clk) begin : monitor
    ent_t e;
    bit   e0, e1, ef;
    if (rst) begin
      exp_q.delete();
      model_tail = 0;
    end else begin
      e0 = 1'b0; e1 = 1'b0; ef = 1'b0;
      if (exp_q.size() > 0 && ready_at(exp_q[0])) begin
        if (exp_q[0].exc) ef = 1'b1; else e0 = 1'b1;
      end
      if (e0 && exp_q.size() > 1 && ready_at(exp_q[1]) && !exp_q[1].exc) e1 = 1'b1;
      chk("commit_valid", commit_valid, {e1, e0});
      chk("flush", flush, ef);
      if (ef) chk("flush_pc", flush_pc, exp_q[0].pc);
      for (int l = 0; l < 2; l++) begin
        if (commit_valid[l]) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL commit_extra: lane %0d retired with no outstanding entry (cycle %0d)", l, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("commit_pc", commit_pc[l], e.pc);
            chk("commit_areg", commit_areg[l], e.areg);
            chk("commit_preg", commit_preg[l], e.preg);
            chk("commit_old_preg", commit_old_preg[l], e.old);
          end
        end
      end
      if (ef) begin
        exp_q.delete();
        model_tail = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    alloc_valid = '0; alloc_dst_areg = '0; alloc_dst_preg = '0;
    alloc_old_preg = '0; alloc_pc = '0; wb_valid = '0; wb_idx = '0; wb_exc = '0;
    do_reset();

    // Dual allocate, out-of-order completion, paired retire.
    step(2'b11, 32'h100, 32'h104, 2'b00, 0, 0, 2'b00);
    step(2'b00, '0, '0, 2'b01, 1, 0, 2'b00);
    step(2'b00, '0, '0, 2'b01, 0, 0, 2'b00);
    idle();
    idle();

    // Exception at head; allocation presented in the flush cycle is dropped.
    step(2'b01, 32'h200, '0, 2'b00, 0, 0, 2'b00);
    step(2'b00, '0, '0, 2'b01, 2, 0, 2'b01);
    step(2'b11, 32'h300, 32'h304, 2'b00, 0, 0, 2'b00);
    chk("flush_drop_count", count, 0);
    chk("flush_drop_idx0", alloc_idx[0], 0);
    idle();

    // Both writeback ports on one index: port 1 decides the exception flag.
    step(2'b11, 32'h400, 32'h404, 2'b00, 0, 0, 2'b00);
    step(2'b00, '0, '0, 2'b11, 0, 0, 2'b01);
    idle();
    step(2'b00, '0, '0, 2'b11, 1, 1, 2'b10);
    idle();
    idle();

    // Head writeback alongside a dual allocation.
    step(2'b01, 32'h500, '0, 2'b00, 0, 0, 2'b00);
    step(2'b11, 32'h504, 32'h508, 2'b01, 0, 0, 2'b00);
    idle();
    drain();

    // Near-full boundary.
    repeat (31) step(2'b01, $urandom, '0, 2'b00, 0, 0, 2'b00);
    chk("near_full_ready", alloc_ready, 0);
    chk("near_full_count", count, 31);
    step(2'b11, $urandom, $urandom, 2'b00, 0, 0, 2'b00);
    chk("ignored_alloc_count", count, 31);
    step(2'b00, '0, '0, 2'b01, exp_q[0].idx, 0, 2'b00);
    idle();
    chk("after_commit_count", count, 30);
    chk("after_commit_ready", alloc_ready, 1);
    step(2'b11, $urandom, $urandom, 2'b00, 0, 0, 2'b00);
    chk("full_flag", full, 1);
    chk("full_ready", alloc_ready, 0);
    drain();

    // Randomized traffic, mid-run reset, more traffic.
    random_run(1200, 30, 0);
    random_run(1200, 70, 3);
    do_reset();
    random_run(600, 60, 2);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameters: DEPTH, default 32, number of entries (power of two, at least 4); AREG_W, default 5, architectural register index width; PREG_W, default 6, physical register tag width; PC_W, default 32, PC width; IDX_W = log2(DEPTH), derived.
REQ-002 clk  in  1  clock, all state changes on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 alloc_valid  in  2  per-lane allocation request from dispatch; lane 1 is valid only when lane 0 is valid.
REQ-005 alloc_dst_areg / alloc_dst_preg / alloc_old_preg  in  2xAREG_W / 2xPREG_W / 2xPREG_W  per-lane destination arch reg, new phys tag, previous phys tag.
REQ-006 alloc_pc  in  2xPC_W  per-lane instruction PC.
REQ-007 alloc_ready  out  1  high when at least 2 entries are free.
REQ-008 alloc_idx  out  2xIDX_W  ROB index assigned to each lane this cycle.
REQ-009 wb_valid / wb_idx / wb_exc  in  2 / 2xIDX_W / 2  completion ports from the execution pipes: entry index and exception flag.
REQ-010 commit_valid  out  2  per-lane retire strobe.
REQ-011 commit_areg / commit_preg / commit_old_preg / commit_pc  out  2xAREG_W / 2xPREG_W / 2xPREG_W / 2xPC_W  retired-entry fields; commit_old_preg goes to the free list.
REQ-012 flush / flush_pc  out  1 / PC_W  exception flush pulse and the faulting PC.
REQ-013 count / empty / full  out  IDX_W+1 / 1 / 1  occupancy status.

Function
REQ-014 Storage is a circular buffer with head and tail pointers of IDX_W+1 bits; the MSB is the wrap bit. count = tail - head, modulo 2^(IDX_W+1).
REQ-015 Each entry holds valid, done, exc, areg, preg, old_preg and pc.
REQ-016 alloc_ready = (DEPTH - count >= 2), computed from registered count only; frees from same-cycle commits are not counted.
REQ-017 Index assignment: alloc_idx[0] = tail[IDX_W-1:0] and alloc_idx[1] = tail+1, both combinational.
REQ-018 On a clock edge with alloc_ready high, each valid lane writes its entry (valid=1, done=0, exc=0, fields captured) and tail advances by popcount(alloc_valid).
REQ-019 When alloc_ready is low, requests are ignored and state is unchanged; dispatch holds and retries.
REQ-020 alloc_valid = 2'b10 is illegal, and the block ignores both lanes for that cycle.
REQ-021 A writeback with wb_valid high sets done=1 and exc=wb_exc on entry wb_idx at the next edge.
REQ-022 A writeback to an entry with valid=0 is ignored.
REQ-023 When both writeback ports target the same index in one cycle, port 1 wins.
REQ-024 Writeback has no same-cycle bypass to commit: an entry completed in cycle N can retire in cycle N+1 at the earliest.
REQ-025 Commit lane 0 (combinational): commit_valid[0] = head entry valid & done & !exc.
REQ-026 Commit lane 1 (combinational): commit_valid[1] = commit_valid[0] & entry(head+1) valid & done & !exc.
REQ-027 commit_* field outputs equal the head / head+1 entry fields whenever the corresponding commit_valid is high.
REQ-028 Retiring entries are cleared to valid=0, and head advances by popcount(commit_valid) at the edge.
REQ-029 Exception at head: when the head entry is valid & done & exc, flush=1 and flush_pc=head pc combinationally, and commit_valid=2'b00.
REQ-030 At the edge after a flush cycle, all valid bits clear, head=tail=0, and allocations presented in the flush cycle are dropped.
REQ-031 An exception on head+1 while head retires blocks lane 1 only; the flush occurs in the following cycle.
REQ-032 Allocate, writeback and commit in the same cycle are all applied independently.
REQ-033 Pointer wrap: index bits roll over from DEPTH-1 to 0 and the wrap bit toggles; full = (count == DEPTH) and empty = (count == 0).
REQ-034 Flush takes precedence over allocation, writeback and commit in the same cycle.

Reset
REQ-035 While rst is high at an edge: head=tail=0 and all valid/done/exc bits are 0.
REQ-036 After that edge: count=0, empty=1, full=0, alloc_ready=1, alloc_idx={1,0}, commit_valid=0, flush=0, flush_pc=0.
REQ-037 Reset asserted mid-operation discards all entries and has priority over every other event.

Verification
REQ-038 Reset, then allocate 2 entries (pc 0x100, 0x104) -> alloc_idx={1,0}, count=2 the next cycle, commit_valid=0.
REQ-039 Writeback idx 1 then idx 0 in successive cycles -> nothing retires after the idx 1 writeback; one cycle after the idx 0 writeback, commit_valid=2'b11 with commit_pc={0x104,0x100}; count=0 after the next edge.
REQ-040 Fill to count=31 with DEPTH=32 -> alloc_ready=0; a dual alloc is ignored and count stays 31; one commit -> count=30 and alloc_ready=1.
REQ-041 Allocate and retire 40 instructions in pairs -> indices wrap 31->0, commit order is preserved, and empty=1 at the end.
REQ-042 Head entry (pc 0x200) written back with wb_exc=1 while an alloc is presented -> flush=1 and flush_pc=0x200 that cycle, commit_valid=0; next cycle count=0, head=tail=0, and the alloc is dropped.
REQ-043 Writeback to the head index in the same cycle as a dual alloc -> the head retires the next cycle and the allocs land at tail, tail+1.
